// File: rtl/chain_code_decoder_pkg.sv
// Shared constants, direction lookup and state encodings for the chain-code decoder.
// Imported by the serial receiver and the contour-walking top level.
package chain_code_pkg;

    localparam int          DEF_CLK_PER_BIT = 11;
    localparam logic [3:0]  END_CODE        = 4'd8;

    localparam logic [3:0]  DIR_0 = 4'd0;
    localparam logic [3:0]  DIR_1 = 4'd1;
    localparam logic [3:0]  DIR_2 = 4'd2;
    localparam logic [3:0]  DIR_3 = 4'd3;
    localparam logic [3:0]  DIR_4 = 4'd4;
    localparam logic [3:0]  DIR_5 = 4'd5;
    localparam logic [3:0]  DIR_6 = 4'd6;
    localparam logic [3:0]  DIR_7 = 4'd7;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_WAIT_START,
        RX_START_CHK,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        TOP_IDLE,
        TOP_RUN,
        TOP_APPLY
    } top_state_t;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } delta_t;

    // Codes outside 0-7 map to a zero move; the caller decides what they mean.
    function automatic delta_t dir_delta(input logic [3:0] code);
        delta_t d;
        d.dx = 2'sb00;
        d.dy = 2'sb00;
        case (code)
            DIR_0: begin d.dx = 2'sb00; d.dy = 2'sb11; end
            DIR_1: begin d.dx = 2'sb01; d.dy = 2'sb11; end
            DIR_2: begin d.dx = 2'sb01; d.dy = 2'sb00; end
            DIR_3: begin d.dx = 2'sb01; d.dy = 2'sb01; end
            DIR_4: begin d.dx = 2'sb00; d.dy = 2'sb01; end
            DIR_5: begin d.dx = 2'sb11; d.dy = 2'sb01; end
            DIR_6: begin d.dx = 2'sb11; d.dy = 2'sb00; end
            DIR_7: begin d.dx = 2'sb11; d.dy = 2'sb11; end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/chain_code_decoder_if.sv
// Control, serial line and pixel/status stream of the chain-code decoder.
// The master side drives arm/start/serial_in; the decoder is the slave.
interface chain_code_decoder_if #(
    parameter int COORD_W = 6,
    parameter int CNT_W   = 16
);
    logic               arm;
    logic [COORD_W-1:0] start_x;
    logic [COORD_W-1:0] start_y;
    logic               serial_in;
    logic               busy;
    logic               code_valid;
    logic [3:0]         code;
    logic               pixel_valid;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;
    logic [CNT_W-1:0]   step_count;
    logic               done;
    logic               error;
    logic               frame_error;
    logic               code_error;

    modport master (
        output arm, start_x, start_y, serial_in,
        input  busy, code_valid, code, pixel_valid, pixel_x, pixel_y,
               step_count, done, error, frame_error, code_error
    );

    modport slave (
        input  arm, start_x, start_y, serial_in,
        output busy, code_valid, code, pixel_valid, pixel_x, pixel_y,
               step_count, done, error, frame_error, code_error
    );
endinterface

// File: rtl/chain_code_uart_rx.sv
// Serial deframer for 4-bit chain codes: synchronizer, start-bit check, LSB-first data, stop check.
// Emits one-cycle code_valid / frame_error pulses; held in RX_IDLE while i_en is low.
module chain_code_uart_rx
    import chain_code_pkg::*;
#(
    parameter int CLK_PER_BIT = DEF_CLK_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic       i_serial,
    output logic       o_code_valid,
    output logic [3:0] o_code,
    output logic       o_frame_error
);
    localparam int CW   = $clog2(CLK_PER_BIT);
    localparam int HALF = CLK_PER_BIT / 2;

    logic            r_sync1;
    logic            r_sync2;
    rx_state_t       r_state;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_bit;
    logic [3:0]      r_shreg;
    logic [3:0]      r_code;
    logic            r_cv;
    logic            r_fe;

    rx_state_t       w_state_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [1:0]      w_bit_nxt;
    logic [3:0]      w_shreg_nxt;
    logic [3:0]      w_code_nxt;
    logic            w_cv_nxt;
    logic            w_fe_nxt;
    logic            w_s;
    logic            w_half_hit;
    logic            w_full_hit;

    assign w_s        = r_sync2;
    assign w_half_hit = (r_cnt == CW'(HALF - 1));
    assign w_full_hit = (r_cnt == CW'(CLK_PER_BIT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shreg_nxt = r_shreg;
        w_code_nxt  = r_code;
        w_cv_nxt    = 1'b0;
        w_fe_nxt    = 1'b0;
        if (!i_en) begin
            w_state_nxt = RX_IDLE;
        end else begin
            case (r_state)
                RX_IDLE: w_state_nxt = RX_WAIT_START;
                RX_WAIT_START: begin
                    if (!w_s) begin
                        w_cnt_nxt   = '0;
                        w_bit_nxt   = 2'd0;
                        w_state_nxt = RX_START_CHK;
                    end
                end
                // Mid-start-bit check rejects short low glitches.
                RX_START_CHK: begin
                    if (w_half_hit) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = w_s ? RX_WAIT_START : RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (w_full_hit) begin
                        w_cnt_nxt          = '0;
                        w_shreg_nxt[r_bit] = w_s;
                        if (r_bit == 2'd3) w_state_nxt = RX_STOP;
                        else               w_bit_nxt   = r_bit + 2'd1;
                    end
                end
                RX_STOP: begin
                    if (w_full_hit) begin
                        w_cnt_nxt = '0;
                        if (w_s) begin
                            w_cv_nxt    = 1'b1;
                            w_code_nxt  = r_shreg;
                            w_state_nxt = RX_WAIT_START;
                        end else begin
                            w_fe_nxt    = 1'b1;
                            w_state_nxt = RX_WAIT_HIGH;
                        end
                    end
                end
                RX_WAIT_HIGH: begin
                    if (w_s) w_state_nxt = RX_WAIT_START;
                end
                default: w_state_nxt = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= 2'd0;
            r_shreg <= 4'd0;
            r_code  <= 4'd0;
            r_cv    <= 1'b0;
            r_fe    <= 1'b0;
        end else begin
            r_sync1 <= i_serial;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shreg <= w_shreg_nxt;
            r_code  <= w_code_nxt;
            r_cv    <= w_cv_nxt;
            r_fe    <= w_fe_nxt;
        end
    end

    assign o_code_valid  = r_cv;
    assign o_code        = r_code;
    assign o_frame_error = r_fe;

endmodule

// File: rtl/chain_code_decoder.sv
// Chain-code decoder top: walks the contour from the armed start pixel using received codes.
// Owns position, step count, busy and the sticky done/error/frame_error/code_error flags.
module chain_code_decoder
    import chain_code_pkg::*;
#(
    parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
    parameter int COORD_W     = 6,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    chain_code_decoder_if.slave   bus
);
    top_state_t          r_state;
    logic [COORD_W-1:0]  r_start_x;
    logic [COORD_W-1:0]  r_start_y;
    logic [COORD_W-1:0]  r_pos_x;
    logic [COORD_W-1:0]  r_pos_y;
    logic [CNT_W-1:0]    r_step;
    logic                r_pix_vld;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic                r_ferr;
    logic                r_cerr;

    top_state_t          w_state_nxt;
    logic [COORD_W-1:0]  w_start_x_nxt;
    logic [COORD_W-1:0]  w_start_y_nxt;
    logic [COORD_W-1:0]  w_pos_x_nxt;
    logic [COORD_W-1:0]  w_pos_y_nxt;
    logic [CNT_W-1:0]    w_step_nxt;
    logic                w_pix_vld_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_error_nxt;
    logic                w_ferr_nxt;
    logic                w_cerr_nxt;

    logic                w_rx_cv;
    logic [3:0]          w_rx_code;
    logic                w_rx_fe;
    delta_t              w_delta;
    logic [COORD_W-1:0]  w_dx_ext;
    logic [COORD_W-1:0]  w_dy_ext;

    chain_code_uart_rx #(
        .CLK_PER_BIT (CLK_PER_BIT)
    ) u_rx (
        .clk           (clk),
        .reset         (reset),
        .i_en          (r_busy),
        .i_serial      (bus.serial_in),
        .o_code_valid  (w_rx_cv),
        .o_code        (w_rx_code),
        .o_frame_error (w_rx_fe)
    );

    // Sign-extended steps; plain unsigned addition then wraps modulo 2^COORD_W.
    assign w_delta  = dir_delta(w_rx_code);
    assign w_dx_ext = {{(COORD_W-2){w_delta.dx[1]}}, w_delta.dx};
    assign w_dy_ext = {{(COORD_W-2){w_delta.dy[1]}}, w_delta.dy};

    always_comb begin
        w_state_nxt   = r_state;
        w_start_x_nxt = r_start_x;
        w_start_y_nxt = r_start_y;
        w_pos_x_nxt   = r_pos_x;
        w_pos_y_nxt   = r_pos_y;
        w_step_nxt    = r_step;
        w_pix_vld_nxt = 1'b0;
        w_busy_nxt    = r_busy;
        w_done_nxt    = r_done;
        w_error_nxt   = r_error;
        w_ferr_nxt    = r_ferr;
        w_cerr_nxt    = r_cerr;
        case (r_state)
            TOP_IDLE: begin
                if (bus.arm) begin
                    w_start_x_nxt = bus.start_x;
                    w_start_y_nxt = bus.start_y;
                    w_pos_x_nxt   = bus.start_x;
                    w_pos_y_nxt   = bus.start_y;
                    w_step_nxt    = '0;
                    w_pix_vld_nxt = 1'b1;
                    w_busy_nxt    = 1'b1;
                    w_done_nxt    = 1'b0;
                    w_error_nxt   = 1'b0;
                    w_ferr_nxt    = 1'b0;
                    w_cerr_nxt    = 1'b0;
                    w_state_nxt   = TOP_RUN;
                end
            end
            TOP_RUN: begin
                if (w_rx_fe) w_ferr_nxt  = 1'b1;
                if (w_rx_cv) w_state_nxt = TOP_APPLY;
            end
            TOP_APPLY: begin
                if (w_rx_code <= DIR_7) begin
                    w_pos_x_nxt   = r_pos_x + w_dx_ext;
                    w_pos_y_nxt   = r_pos_y + w_dy_ext;
                    w_pix_vld_nxt = 1'b1;
                    if (r_step != {CNT_W{1'b1}}) w_step_nxt = r_step + 1'b1;
                    w_state_nxt   = TOP_RUN;
                end else if (w_rx_code == END_CODE) begin
                    w_done_nxt  = 1'b1;
                    w_error_nxt = (r_pos_x != r_start_x) || (r_pos_y != r_start_y);
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = TOP_IDLE;
                end else begin
                    w_cerr_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = TOP_IDLE;
                end
            end
            default: w_state_nxt = TOP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= TOP_IDLE;
            r_start_x <= '0;
            r_start_y <= '0;
            r_pos_x   <= '0;
            r_pos_y   <= '0;
            r_step    <= '0;
            r_pix_vld <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_ferr    <= 1'b0;
            r_cerr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_x <= w_start_x_nxt;
            r_start_y <= w_start_y_nxt;
            r_pos_x   <= w_pos_x_nxt;
            r_pos_y   <= w_pos_y_nxt;
            r_step    <= w_step_nxt;
            r_pix_vld <= w_pix_vld_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_error   <= w_error_nxt;
            r_ferr    <= w_ferr_nxt;
            r_cerr    <= w_cerr_nxt;
        end
    end

    assign bus.busy        = r_busy;
    assign bus.code_valid  = w_rx_cv;
    assign bus.code        = w_rx_code;
    assign bus.pixel_valid = r_pix_vld;
    assign bus.pixel_x     = r_pos_x;
    assign bus.pixel_y     = r_pos_y;
    assign bus.step_count  = r_step;
    assign bus.done        = r_done;
    assign bus.error       = r_error;
    assign bus.frame_error = r_ferr;
    assign bus.code_error  = r_cerr;

endmodule

// File: tb/tb_chain_code_decoder.sv
// Directed bench for chain_code_decoder: expected pixels/codes queued by the stimulus,
// popped and compared by a monitor whenever the decoder strobes pixel_valid or code_valid.
module tb_chain_code_decoder;
    localparam int CPB     = 11;
    localparam int COORD_W = 6;
    localparam int CNT_W   = 16;

    logic clk;
    logic reset;

    chain_code_decoder_if #(.COORD_W(COORD_W), .CNT_W(CNT_W)) bus ();

    chain_code_decoder #(
        .CLK_PER_BIT (CPB),
        .COORD_W     (COORD_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_px[$];
    int exp_py[$];
    int exp_code[$];
    int mon_x, mon_y, mon_c;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the head of its expectation queue.
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.pixel_valid === 1'b1) begin
                n_checks++;
                if (exp_px.size() == 0) begin
                    n_fail++;
                    $display("FAIL pixel_unexpected: got (%0d,%0d), required no pixel",
                             bus.pixel_x, bus.pixel_y);
                end else begin
                    mon_x = exp_px.pop_front();
                    mon_y = exp_py.pop_front();
                    if (int'(bus.pixel_x) != mon_x || int'(bus.pixel_y) != mon_y) begin
                        n_fail++;
                        $display("FAIL pixel: got (%0d,%0d), required (%0d,%0d)",
                                 bus.pixel_x, bus.pixel_y, mon_x, mon_y);
                    end
                end
            end
            if (bus.code_valid === 1'b1) begin
                n_checks++;
                if (exp_code.size() == 0) begin
                    n_fail++;
                    $display("FAIL code_unexpected: got %0d, required no code", bus.code);
                end else begin
                    mon_c = exp_code.pop_front();
                    if (int'(bus.code) != mon_c) begin
                        n_fail++;
                        $display("FAIL code: got %0d, required %0d", bus.code, mon_c);
                    end
                end
            end
        end
    end

    task automatic push_pix(input int x, input int y);
        exp_px.push_back(x);
        exp_py.push_back(y);
    endtask

    task automatic do_arm(input int x, input int y);
        @(negedge clk);
        bus.arm     = 1'b1;
        bus.start_x = COORD_W'(x);
        bus.start_y = COORD_W'(y);
        @(negedge clk);
        bus.arm = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_frame(input logic [3:0] code, input logic stop);
        if (stop) exp_code.push_back(int'(code));
        bus.serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.serial_in = code[i];
            repeat (CPB) @(negedge clk);
        end
        bus.serial_in = stop;
        repeat (CPB) @(negedge clk);
        bus.serial_in = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (bus.busy === 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk({name, "_busy_timeout"}, int'(bus.busy), 0);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_busy"},        int'(bus.busy),        0);
        chk({name, "_done"},        int'(bus.done),        0);
        chk({name, "_error"},       int'(bus.error),       0);
        chk({name, "_frame_error"}, int'(bus.frame_error), 0);
        chk({name, "_code_error"},  int'(bus.code_error),  0);
        chk({name, "_step"},        int'(bus.step_count),  0);
        chk({name, "_pixel_x"},     int'(bus.pixel_x),     0);
        chk({name, "_pixel_y"},     int'(bus.pixel_y),     0);
        chk({name, "_pixel_valid"}, int'(bus.pixel_valid), 0);
        chk({name, "_code_valid"},  int'(bus.code_valid),  0);
        chk({name, "_code"},        int'(bus.code),        0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.arm       = 1'b0;
        bus.start_x   = '0;
        bus.start_y   = '0;
        bus.serial_in = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Closed square
        push_pix(10, 20);
        do_arm(10, 20);
        chk("sq_busy_armed", int'(bus.busy), 1);
        push_pix(11, 20); send_frame(4'd2, 1'b1);
        push_pix(11, 21); send_frame(4'd4, 1'b1);
        push_pix(10, 21); send_frame(4'd6, 1'b1);
        push_pix(10, 20); send_frame(4'd0, 1'b1);
        send_frame(4'd8, 1'b1);
        wait_idle("sq");
        chk("sq_step",  int'(bus.step_count), 4);
        chk("sq_done",  int'(bus.done),       1);
        chk("sq_error", int'(bus.error),      0);

        // Open contour, with an arm while busy that must be ignored
        push_pix(5, 5);
        do_arm(5, 5);
        push_pix(6, 5); send_frame(4'd2, 1'b1);
        do_arm(40, 40);
        push_pix(7, 5); send_frame(4'd2, 1'b1);
        send_frame(4'd8, 1'b1);
        wait_idle("open");
        chk("open_step",  int'(bus.step_count), 2);
        chk("open_done",  int'(bus.done),       1);
        chk("open_error", int'(bus.error),      1);

        // Framing error then a good frame
        push_pix(30, 30);
        do_arm(30, 30);
        chk("arm_clears_done", int'(bus.done), 0);
        send_frame(4'd3, 1'b0);
        repeat (5) @(negedge clk);
        chk("fe_flag",  int'(bus.frame_error), 1);
        chk("fe_pos_x", int'(bus.pixel_x),     30);
        chk("fe_pos_y", int'(bus.pixel_y),     30);
        chk("fe_step",  int'(bus.step_count),  0);
        chk("fe_busy",  int'(bus.busy),        1);
        push_pix(30, 31); send_frame(4'd4, 1'b1);
        send_frame(4'd8, 1'b1);
        wait_idle("fe");
        chk("fe_sticky", int'(bus.frame_error), 1);
        chk("fe_done",   int'(bus.done),        1);
        chk("fe_step2",  int'(bus.step_count),  1);

        // Glitch then illegal code
        push_pix(1, 2);
        do_arm(1, 2);
        chk("arm_clears_fe", int'(bus.frame_error), 0);
        @(negedge clk);
        bus.serial_in = 1'b0;
        repeat (2) @(negedge clk);
        bus.serial_in = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_step", int'(bus.step_count), 0);
        chk("glitch_busy", int'(bus.busy),       1);
        send_frame(4'd12, 1'b1);
        wait_idle("ill");
        chk("ill_code_error", int'(bus.code_error), 1);
        chk("ill_done",       int'(bus.done),       0);
        chk("ill_pos_x",      int'(bus.pixel_x),    1);

        // Wrap-around
        push_pix(63, 0);
        do_arm(63, 0);
        chk("arm_clears_ce", int'(bus.code_error), 0);
        push_pix(0, 63);  send_frame(4'd1, 1'b1);
        push_pix(63, 62); send_frame(4'd7, 1'b1);
        send_frame(4'd8, 1'b1);
        wait_idle("wrap");
        chk("wrap_done",  int'(bus.done),       1);
        chk("wrap_error", int'(bus.error),      1);
        chk("wrap_step",  int'(bus.step_count), 2);

        // Reset during data bit 2 of code 5
        push_pix(7, 7);
        do_arm(7, 7);
        bus.serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        bus.serial_in = 1'b1;
        repeat (CPB) @(negedge clk);
        bus.serial_in = 1'b0;
        repeat (CPB) @(negedge clk);
        bus.serial_in = 1'b1;
        repeat (CPB / 2 + 2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("midrst");
        reset = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        chk("midrst_after_busy", int'(bus.busy), 0);
        push_pix(3, 3);
        do_arm(3, 3);
        push_pix(4, 4); send_frame(4'd3, 1'b1);
        send_frame(4'd8, 1'b1);
        wait_idle("post");
        chk("post_done",  int'(bus.done),       1);
        chk("post_error", int'(bus.error),      1);
        chk("post_step",  int'(bus.step_count), 1);

        repeat (10) @(negedge clk);
        chk("left_pixels", exp_px.size(),   0);
        chk("left_codes",  exp_code.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
